// File: rtl/hwpe_stream_buffer_source_if.sv
// HWPE-Stream handshake bundle: valid/ready/data/strb with source and sink views.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [STRB_WIDTH-1:0] strb;

  modport source (output valid, output data, output strb, input ready);
  modport sink   (input valid, input data, input strb, output ready);
endinterface

// File: rtl/hwpe_stream_buffer_source.sv
// Register buffer loaded through a write port, replayed len*repeat times as an
// HWPE-Stream source under start/len/repeat control.
module hwpe_stream_buffer_source #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BUF_DEPTH  = 8,
  parameter int unsigned CNT_WIDTH  = 16,
  localparam int unsigned AW         = $clog2(BUF_DEPTH),
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  wr_en_i,
  input  logic [AW-1:0]         wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [STRB_WIDTH-1:0] wr_strb_i,
  input  logic                  start_i,
  input  logic [AW:0]           len_i,
  input  logic [CNT_WIDTH-1:0]  repeat_i,
  output logic                  busy_o,
  output logic                  done_o,
  hwpe_stream_intf_stream.source stream_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                           state_q;
  logic [DATA_WIDTH+STRB_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [AW-1:0]                    rd_ptr_q;
  logic [CNT_WIDTH-1:0]             rep_cnt_q;
  logic [AW:0]                      len_q;
  logic [CNT_WIDTH-1:0]             rep_q;

  logic valid;
  logic handshake;
  logic last_in_pass;
  logic last_pass;

  assign valid        = (state_q == RUN);
  assign handshake    = valid & stream_o.ready;
  assign last_in_pass = ({1'b0, rd_ptr_q} == (len_q - (AW+1)'(1)));
  assign last_pass    = (rep_cnt_q == (rep_q - CNT_WIDTH'(1)));

  // Outputs decode registered state only; the buffer is frozen outside IDLE,
  // so the presented beat stays stable across stalls.
  assign stream_o.valid = valid;
  assign stream_o.data  = valid ? mem_q[rd_ptr_q][DATA_WIDTH+STRB_WIDTH-1:STRB_WIDTH] : '0;
  assign stream_o.strb  = valid ? mem_q[rd_ptr_q][STRB_WIDTH-1:0] : '0;
  assign busy_o         = (state_q != IDLE);
  assign done_o         = (state_q == DONE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      rd_ptr_q  <= '0;
      rep_cnt_q <= '0;
      len_q     <= '0;
      rep_q     <= '0;
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (clear_i) begin
      state_q   <= IDLE;
      rd_ptr_q  <= '0;
      rep_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (wr_en_i) begin
            mem_q[wr_addr_i] <= {wr_data_i, wr_strb_i};
          end
          if (start_i) begin
            len_q     <= len_i;
            rep_q     <= repeat_i;
            rd_ptr_q  <= '0;
            rep_cnt_q <= '0;
            state_q   <= ((len_i == '0) || (repeat_i == '0)) ? DONE : RUN;
          end
        end
        RUN: begin
          if (handshake) begin
            if (last_in_pass) begin
              rd_ptr_q  <= '0;
              rep_cnt_q <= rep_cnt_q + CNT_WIDTH'(1);
              if (last_pass) begin
                state_q <= DONE;
              end
            end else begin
              rd_ptr_q <= rd_ptr_q + AW'(1);
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hwpe_stream_buffer_source.sv
// Scoreboard bench for hwpe_stream_buffer_source: directed loads/replays push
// expected beats; a negedge monitor pops them on every handshake.
module tb_hwpe_stream_buffer_source;

  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned AW = 3;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst_i, clear_i, wr_en_i, start_i;
  logic [AW-1:0] wr_addr_i;
  logic [DW-1:0] wr_data_i;
  logic [SW-1:0] wr_strb_i;
  logic [AW:0]   len_i;
  logic [CW-1:0] repeat_i;
  logic          busy_o, done_o;

  hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) stream ();

  hwpe_stream_buffer_source #(
    .DATA_WIDTH(DW),
    .BUF_DEPTH (8),
    .CNT_WIDTH (CW)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .clear_i  (clear_i),
    .wr_en_i  (wr_en_i),
    .wr_addr_i(wr_addr_i),
    .wr_data_i(wr_data_i),
    .wr_strb_i(wr_strb_i),
    .start_i  (start_i),
    .len_i    (len_i),
    .repeat_i (repeat_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .stream_o (stream)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  int exp_done = 0;

  logic [DW+SW-1:0] exp_q [$];
  logic [DW+SW-1:0] model [8];
  logic [4:0]       rdy_pat = 5'b10010; // per-cycle ready: 0,1,0,0,1

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: checks every handshake against the scoreboard, stall stability, idle zeros.
  logic          stall_prev = 1'b0;
  logic [DW+SW-1:0] held;
  always @(negedge clk) begin
    if (!rst_i) begin
      if (stream.valid) begin
        if (stall_prev) chk("stall_stable", 64'({stream.data, stream.strb}), 64'(held));
        if (stream.ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 64'({stream.data, stream.strb}), 64'hDEAD_0000);
          end else begin
            chk("beat", 64'({stream.data, stream.strb}), 64'(exp_q.pop_front()));
          end
        end
      end else begin
        chk("idle_zero", 64'({stream.data, stream.strb}), 64'd0);
      end
      held       = {stream.data, stream.strb};
      stall_prev = stream.valid & ~stream.ready;
      if (done_o) done_cnt++;
    end
  end

  task automatic wr(input int addr, input logic [DW-1:0] d, input logic [SW-1:0] s);
    wr_en_i   = 1'b1;
    wr_addr_i = AW'(addr);
    wr_data_i = d;
    wr_strb_i = s;
    tick();
    wr_en_i   = 1'b0;
    model[addr] = {d, s};
  endtask

  task automatic start_replay(input int len, input int rep);
    for (int r = 0; r < rep; r++)
      for (int i = 0; i < len; i++) exp_q.push_back(model[i]);
    start_i  = 1'b1;
    len_i    = (AW+1)'(len);
    repeat_i = CW'(rep);
    tick();
    start_i  = 1'b0;
  endtask

  task automatic run_until_done(input bit pattern);
    bit seen = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (done_o) begin
        seen = 1'b1;
        break;
      end
      stream.ready = pattern ? rdy_pat[c % 5] : 1'b1;
      tick();
    end
    chk("done_seen", 64'(seen), 64'd1);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    exp_done++;
    start_i = 1'b0;
    wr_en_i = 1'b0;
    stream.ready = 1'b1;
    tick();
    chk("done_one_cycle", 64'(done_o), 64'd0);
    chk("idle_after_done", 64'(busy_o), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) model[i] = '0;
    // 1: reset with garbage inputs
    rst_i = 1'b1; clear_i = 1'b0; wr_en_i = 1'b1; start_i = 1'b1;
    wr_addr_i = 3'd2; wr_data_i = 32'hBADC0DE5; wr_strb_i = 4'hA;
    len_i = 4'd3; repeat_i = 16'd2; stream.ready = 1'b1;
    tick(); tick();
    chk("rst_valid", 64'(stream.valid), 64'd0);
    chk("rst_data", 64'(stream.data), 64'd0);
    chk("rst_strb", 64'(stream.strb), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    rst_i = 1'b0; wr_en_i = 1'b0; start_i = 1'b0;
    tick();
    start_replay(1, 1);
    run_until_done(1'b0);

    // 2: basic timing
    for (int i = 0; i < 4; i++) wr(i, DW'(32'hA0 + i), 4'hF);
    start_replay(4, 1);
    chk("t1_valid", 64'(stream.valid), 64'd1);
    chk("t1_busy", 64'(busy_o), 64'd1);
    chk("t1_data", 64'(stream.data), 64'hA0);
    tick(); tick(); tick();
    chk("t4_valid", 64'(stream.valid), 64'd1);
    chk("t4_done", 64'(done_o), 64'd0);
    tick();
    chk("t5_done", 64'(done_o), 64'd1);
    chk("t5_valid", 64'(stream.valid), 64'd0);
    exp_done++;
    tick();
    chk("t6_done", 64'(done_o), 64'd0);
    chk("t6_busy", 64'(busy_o), 64'd0);

    // 3: backpressure
    start_replay(4, 1);
    run_until_done(1'b1);

    // 4: repeat and pointer wrap
    for (int i = 0; i < 8; i++) wr(i, DW'(32'h10 + i), SW'(i + 1));
    start_replay(8, 3);
    run_until_done(1'b0);
    start_replay(2, 3);
    run_until_done(1'b1);

    // 5: abort after two handshakes
    exp_q.push_back(model[0]);
    exp_q.push_back(model[1]);
    start_i = 1'b1; len_i = 4'd8; repeat_i = 16'd1; stream.ready = 1'b1;
    tick();
    start_i = 1'b0;
    tick(); tick();
    clear_i = 1'b1; stream.ready = 1'b0;
    tick();
    clear_i = 1'b0;
    chk("abort_valid", 64'(stream.valid), 64'd0);
    chk("abort_busy", 64'(busy_o), 64'd0);
    chk("abort_done", 64'(done_o), 64'd0);
    chk("abort_queue", 64'(exp_q.size()), 64'd0);
    tick();
    chk("abort_no_done", 64'(done_o), 64'd0);
    start_replay(4, 1);
    chk("restart_data", 64'(stream.data), 64'h10);
    run_until_done(1'b0);

    // 6: zero length / zero repeat, and ignored start/write during RUN
    start_replay(0, 5);
    chk("len0_valid", 64'(stream.valid), 64'd0);
    chk("len0_done", 64'(done_o), 64'd1);
    run_until_done(1'b0);
    start_replay(3, 0);
    chk("rep0_done", 64'(done_o), 64'd1);
    run_until_done(1'b0);
    start_replay(3, 2);
    start_i = 1'b1; len_i = 4'd1; repeat_i = 16'd1;
    wr_en_i = 1'b1; wr_addr_i = 3'd0; wr_data_i = 32'hDEAD; wr_strb_i = 4'h0;
    run_until_done(1'b0);
    start_replay(1, 1);
    run_until_done(1'b0);

    tick();
    chk("done_pulses", 64'(done_cnt), 64'(exp_done));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
